// File: rtl/hbm_rqst_arbiter.sv
// Round-robin read-request arbiter for one HBM pseudo-channel with in-order response routing.
// Optional HBM_ARB_ERR_CHECK_EN adds a sticky rsp_underflow_err output.
module hbm_rqst_arbiter #(
    parameter int HBM_AWIDTH        = 33,
    parameter int GROUP_CORE_NUM    = 4,
    parameter int CORE_SEL_WIDTH    = 2,
    parameter int OUTSTANDING_DEPTH = 32,
    parameter int OUT_CNT_WIDTH     = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [GROUP_CORE_NUM*HBM_AWIDTH-1:0] core_rd_addr,
    input  logic [GROUP_CORE_NUM-1:0]            core_rd_valid,
    output logic [GROUP_CORE_NUM-1:0]            core_rd_ready,
    input  logic                                 stage_full,
    output logic [HBM_AWIDTH-1:0]                rd_hbm_edge_addr,
    output logic                                 rd_hbm_edge_valid,
    input  logic                                 hbm_rsp_valid,
    output logic [GROUP_CORE_NUM-1:0]            rsp_core_sel,
    output logic                                 rsp_core_sel_valid,
    output logic [OUT_CNT_WIDTH-1:0]             outstanding_cnt,
`ifdef HBM_ARB_ERR_CHECK_EN
    output logic                                 rsp_underflow_err,
`endif
    output logic                                 idle
);
    localparam int PTR_W = $clog2(OUTSTANDING_DEPTH);
    localparam logic [OUT_CNT_WIDTH-1:0]  CNT_FULL  = OUT_CNT_WIDTH'(OUTSTANDING_DEPTH);
    localparam logic [CORE_SEL_WIDTH-1:0] LAST_CORE = CORE_SEL_WIDTH'(GROUP_CORE_NUM - 1);

    logic [CORE_SEL_WIDTH-1:0] rr_ptr;
    logic [CORE_SEL_WIDTH-1:0] grant_idx;
    logic [CORE_SEL_WIDTH-1:0] head_tag;
    logic                      grant_hit;
    logic                      can_issue;
    logic                      accept;
    logic                      pop;
    logic                      tags_empty;
    logic [CORE_SEL_WIDTH-1:0] tag_mem [OUTSTANDING_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;

    // The outstanding counter doubles as the tag FIFO occupancy.
    assign tags_empty = (outstanding_cnt == '0);
    assign can_issue  = !rst && !stage_full && (outstanding_cnt < CNT_FULL);
    assign accept     = grant_hit && can_issue;
    assign pop        = hbm_rsp_valid && !tags_empty;
    assign head_tag   = tag_mem[rd_ptr];

    always_comb begin
        int unsigned idx;
        idx       = '0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < GROUP_CORE_NUM; k++) begin
            idx = (32'(rr_ptr) + k) % 32'(GROUP_CORE_NUM);
            if (!grant_hit && core_rd_valid[CORE_SEL_WIDTH'(idx)]) begin
                grant_hit = 1'b1;
                grant_idx = CORE_SEL_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        core_rd_ready = '0;
        if (accept) begin
            core_rd_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr             <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            rd_hbm_edge_addr   <= '0;
            rd_hbm_edge_valid  <= 1'b0;
            rsp_core_sel       <= '0;
            rsp_core_sel_valid <= 1'b0;
            outstanding_cnt    <= '0;
        end else begin
            rd_hbm_edge_valid <= accept;
            if (accept) begin
                rd_hbm_edge_addr <= core_rd_addr[grant_idx*HBM_AWIDTH +: HBM_AWIDTH];
                wr_ptr           <= wr_ptr + PTR_W'(1);
                rr_ptr           <= (grant_idx == LAST_CORE) ? '0 : grant_idx + CORE_SEL_WIDTH'(1);
            end
            rsp_core_sel_valid <= pop;
            rsp_core_sel       <= '0;
            if (pop) begin
                rsp_core_sel[head_tag] <= 1'b1;
                rd_ptr                 <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   outstanding_cnt <= outstanding_cnt + OUT_CNT_WIDTH'(1);
                2'b01:   outstanding_cnt <= outstanding_cnt - OUT_CNT_WIDTH'(1);
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

`ifdef HBM_ARB_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_underflow_err <= 1'b0;
        end else if (hbm_rsp_valid && tags_empty) begin
            rsp_underflow_err <= 1'b1;
        end
    end
`endif

    assign idle = !rst && tags_empty && !(|core_rd_valid) && !rd_hbm_edge_valid;

endmodule

// File: tb/tb_hbm_rqst_arbiter.sv
// Self-checking bench for hbm_rqst_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hbm_rqst_arbiter;
    localparam int AW    = 33;
    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   core_rd_addr;
    logic [N-1:0]      core_rd_valid;
    logic [N-1:0]      core_rd_ready;
    logic              stage_full;
    logic [AW-1:0]     rd_hbm_edge_addr;
    logic              rd_hbm_edge_valid;
    logic              hbm_rsp_valid;
    logic [N-1:0]      rsp_core_sel;
    logic              rsp_core_sel_valid;
    logic [CW-1:0]     outstanding_cnt;
`ifdef HBM_ARB_ERR_CHECK_EN
    logic              rsp_underflow_err;
`endif
    logic              idle;

    always #5 clk = ~clk;

    hbm_rqst_arbiter #(
        .HBM_AWIDTH(AW),
        .GROUP_CORE_NUM(N),
        .CORE_SEL_WIDTH(SW),
        .OUTSTANDING_DEPTH(DEPTH),
        .OUT_CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_rd_addr(core_rd_addr),
        .core_rd_valid(core_rd_valid),
        .core_rd_ready(core_rd_ready),
        .stage_full(stage_full),
        .rd_hbm_edge_addr(rd_hbm_edge_addr),
        .rd_hbm_edge_valid(rd_hbm_edge_valid),
        .hbm_rsp_valid(hbm_rsp_valid),
        .rsp_core_sel(rsp_core_sel),
        .rsp_core_sel_valid(rsp_core_sel_valid),
        .outstanding_cnt(outstanding_cnt),
`ifdef HBM_ARB_ERR_CHECK_EN
        .rsp_underflow_err(rsp_underflow_err),
`endif
        .idle(idle)
    );

    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 0;
    logic [N-1:0] acc_last = '0;
    logic [AW-1:0] a_tab [N];

    // Reference model: tags in flight as a queue, plus the expected registered outputs.
    int            q[$];
    int            m_rr = 0;
    logic          m_ev = 0;
    logic [AW-1:0] m_addr = '0;
    logic [N-1:0]  m_sel = '0;
    logic          m_sv = 0;
    logic          m_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (core_rd_valid[c]) return c;
        end
        return -1;
    endfunction

    initial forever begin
        int g;
        bit acc;
        bit popd;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rr = 0; m_ev = 0; m_addr = '0; m_sel = '0; m_sv = 0; m_err = 0;
        end else begin
            g    = model_grant();
            acc  = (g >= 0) && !stage_full && (q.size() < DEPTH);
            popd = hbm_rsp_valid && (q.size() > 0);
            if (hbm_rsp_valid && q.size() == 0) m_err = 1;
            m_sv  = popd;
            m_sel = '0;
            if (popd) begin
                m_sel[q[0]] = 1'b1;
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(g);
                m_addr = core_rd_addr[g*AW +: AW];
                m_rr   = (g + 1) % N;
            end
            m_ev = acc;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        if (cmp_en) begin
            g  = model_grant();
            er = '0;
            if (!rst && !stage_full && q.size() < DEPTH && g >= 0) er[g] = 1'b1;
            chk("ready", core_rd_ready, er);
            chk("edge_valid", rd_hbm_edge_valid, m_ev);
            chk("edge_addr", rd_hbm_edge_addr, m_addr);
            chk("rsp_sel", rsp_core_sel, m_sel);
            chk("rsp_sel_valid", rsp_core_sel_valid, m_sv);
            chk("outstanding", outstanding_cnt, q.size());
            chk("idle", idle, !rst && q.size() == 0 && core_rd_valid == '0 && !m_ev);
`ifdef HBM_ARB_ERR_CHECK_EN
            chk("underflow_err", rsp_underflow_err, m_err);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        acc_last = core_rd_ready & core_rd_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        core_rd_valid = '0;
        while (outstanding_cnt != 0 && n < 80) begin
            hbm_rsp_valid = 1'b1;
            tick();
            n++;
        end
        hbm_rsp_valid = 1'b0;
        chk("drain_cnt", outstanding_cnt, 0);
    endtask

    initial begin
        logic [63:0] r;
        int rsp_pct;
        rst = 1'b1; core_rd_valid = '0; core_rd_addr = '0; stage_full = 1'b0; hbm_rsp_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            r = {$urandom(), $urandom()};
            a_tab[i] = r[AW-1:0];
        end
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        chk("rst_cnt", outstanding_cnt, 0);
        chk("rst_ev", rd_hbm_edge_valid, 0);
        chk("rst_sv", rsp_core_sel_valid, 0);
        chk("rst_ready", core_rd_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_after_rst", idle, 1);
        for (int i = 0; i < N; i++) core_rd_addr[i*AW +: AW] = a_tab[i];

        // Round-robin with all cores requesting: grants 0,1,2,3,0.
        core_rd_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("rr_ready", core_rd_ready, 4'b0001 << (n % 4));
            tick();
            chk("rr_ev", rd_hbm_edge_valid, 1);
            chk("rr_addr", rd_hbm_edge_addr, a_tab[n % 4]);
        end
        drain();

        // Back-pressure on core 2.
        stage_full = 1'b1;
        core_rd_valid = 4'b0100;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("bp_ready", core_rd_ready, 0);
            tick();
            chk("bp_ev", rd_hbm_edge_valid, 0);
        end
        stage_full = 1'b0;
        #1;
        chk("bp_release_ready", core_rd_ready, 4'b0100);
        tick();
        chk("bp_release_ev", rd_hbm_edge_valid, 1);
        chk("bp_release_addr", rd_hbm_edge_addr, a_tab[2]);
        drain();

        // Outstanding limit from core 1.
        core_rd_valid = 4'b0010;
        repeat (DEPTH) tick();
        chk("lim_cnt", outstanding_cnt, 32);
        chk("lim_ready", core_rd_ready, 0);
        hbm_rsp_valid = 1'b1;
        tick();
        hbm_rsp_valid = 1'b0;
        chk("lim_sel", rsp_core_sel, 4'b0010);
        chk("lim_sv", rsp_core_sel_valid, 1);
        chk("lim_cnt_dec", outstanding_cnt, 31);
        chk("lim_ready_back", core_rd_ready, 4'b0010);
        tick();
        chk("lim_cnt_refill", outstanding_cnt, 32);
        drain();

        // Response routing for cores 3,0,0,2.
        core_rd_valid = 4'b1000; tick();
        core_rd_valid = 4'b0001; tick();
        tick();
        core_rd_valid = 4'b0100; tick();
        core_rd_valid = '0;
        hbm_rsp_valid = 1'b1;
        tick(); chk("route0", rsp_core_sel, 4'b1000);
        tick(); chk("route1", rsp_core_sel, 4'b0001);
        tick(); chk("route2", rsp_core_sel, 4'b0001);
        tick(); chk("route3", rsp_core_sel, 4'b0100);
        hbm_rsp_valid = 1'b0;
        chk("route_cnt", outstanding_cnt, 0);
        chk("route_idle", idle, 1);

        // Simultaneous accept and response at count 5.
        core_rd_valid = 4'b1000; tick();
        core_rd_valid = 4'b0001; repeat (4) tick();
        chk("sim_cnt_pre", outstanding_cnt, 5);
        core_rd_valid = 4'b0010;
        hbm_rsp_valid = 1'b1;
        #1;
        chk("sim_ready", core_rd_ready, 4'b0010);
        tick();
        core_rd_valid = '0;
        hbm_rsp_valid = 1'b0;
        chk("sim_cnt", outstanding_cnt, 5);
        chk("sim_sel", rsp_core_sel, 4'b1000);
        chk("sim_sv", rsp_core_sel_valid, 1);
        chk("sim_addr", rd_hbm_edge_addr, a_tab[1]);
        drain();

        // Reset with reads in flight, then a response into the empty tag store.
        core_rd_valid = 4'b0001; repeat (3) tick();
        core_rd_valid = '0;
        chk("rs_cnt_pre", outstanding_cnt, 3);
        rst = 1'b1; tick();
        chk("rs_cnt", outstanding_cnt, 0);
        chk("rs_ev", rd_hbm_edge_valid, 0);
        chk("rs_sel", rsp_core_sel, 0);
        rst = 1'b0;
        hbm_rsp_valid = 1'b1; tick();
        hbm_rsp_valid = 1'b0;
        chk("uf_sv", rsp_core_sel_valid, 0);
        chk("uf_sel", rsp_core_sel, 0);
        chk("uf_cnt", outstanding_cnt, 0);
`ifdef HBM_ARB_ERR_CHECK_EN
        chk("uf_err", rsp_underflow_err, 1);
        repeat (3) tick();
        chk("uf_err_sticky", rsp_underflow_err, 1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("uf_err_clr", rsp_underflow_err, 0);
`endif

        // Randomized traffic; cores hold address/valid until accepted.
        rsp_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) rsp_pct = (cyc % 1000 == 0) ? 12 : 55;
            rst           = ($urandom_range(0, 299) == 0);
            stage_full    = ($urandom_range(0, 3) == 0);
            hbm_rsp_valid = ($urandom_range(0, 99) < rsp_pct);
            for (int i = 0; i < N; i++) begin
                if (!core_rd_valid[i] || acc_last[i]) begin
                    r = {$urandom(), $urandom()};
                    core_rd_valid[i] = ($urandom_range(0, 2) != 0);
                    core_rd_addr[i*AW +: AW] = r[AW-1:0];
                end
            end
            tick();
        end
        rst = 1'b0;
        core_rd_valid = '0;
        hbm_rsp_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hbm_rqst_arbiter.md
# hbm_rqst_arbiter

Shares one HBM pseudo-channel read-request path between the GROUP_CORE_NUM cores of a group. The block round-robins core edge-address requests into the per-channel send path (edge-address FIFO input, honouring its `stage_full`). It records which core issued each request and routes each in-order response beat back to that core as a one-hot select. It bounds outstanding reads so the response tag store can never overflow.

## Interface
Parameters:
- `HBM_AWIDTH`, 33, HBM edge address width.
- `GROUP_CORE_NUM`, 4, number of requesting cores (≥2).
- `CORE_SEL_WIDTH`, 2, log2(GROUP_CORE_NUM).
- `OUTSTANDING_DEPTH`, 32, maximum in-flight reads; also the tag FIFO depth (power of two).
- `OUT_CNT_WIDTH`, 6, log2(OUTSTANDING_DEPTH)+1.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, synchronous, active-high.
- `core_rd_addr`, in, GROUP_CORE_NUM*HBM_AWIDTH, per-core request address; core i occupies slice [(i+1)*HBM_AWIDTH-1 : i*HBM_AWIDTH].
- `core_rd_valid`, in, GROUP_CORE_NUM, per-core request valid.
- `core_rd_ready`, out, GROUP_CORE_NUM, per-core accept; at most one bit set.
- `stage_full`, in, 1, back-pressure from the send-path FIFO (prog_full).
- `rd_hbm_edge_addr`, out, HBM_AWIDTH, granted address to the send path.
- `rd_hbm_edge_valid`, out, 1, write strobe to the send path.
- `hbm_rsp_valid`, in, 1, one in-order response beat returned on this channel.
- `rsp_core_sel`, out, GROUP_CORE_NUM, one-hot destination core of the current response.
- `rsp_core_sel_valid`, out, 1, qualifies `rsp_core_sel`.
- `outstanding_cnt`, out, OUT_CNT_WIDTH, reads issued but not yet answered.
- `idle`, out, 1, high when outstanding_cnt==0, no core_rd_valid is set, and rd_hbm_edge_valid is low.

## Operation
- `can_issue = !stage_full && outstanding_cnt < OUTSTANDING_DEPTH`.
- **Grant selection (combinational):**
  - Choose the first set `core_rd_valid` bit, searching from `rr_ptr` upward with wrap.
  - `core_rd_ready[g] = can_issue` for the chosen core g; all other ready bits are 0.
- **Acceptance:** a transfer occurs when `core_rd_valid[g] && core_rd_ready[g]`. On acceptance:
  - `rd_hbm_edge_addr` is registered from core g's slice.
  - g is pushed into the tag FIFO.
  - `rr_ptr` becomes (g+1) mod GROUP_CORE_NUM.
  - `outstanding_cnt` increments.
- **No request or cannot issue:** `rr_ptr` holds, and `rd_hbm_edge_valid` deasserts next cycle.
- **Response:** `hbm_rsp_valid` pops the tag FIFO head. Next cycle:
  - `rsp_core_sel` = one-hot of the popped tag.
  - `rsp_core_sel_valid` = 1.
  - `outstanding_cnt` decrements.
- **Simultaneous accept and response:** the counter is unchanged, and the FIFO pushes and pops in the same cycle.
- **Address:** passes through unmodified. The send path applies any region offset.
- **Reset:** all outputs are 0, `rr_ptr`=0, and the tag FIFO is emptied.
  - Reset mid-operation discards in-flight tags.
  - Responses arriving after reset while the FIFO is empty follow the Configuration rules.

## Timing
- Request-to-`rd_hbm_edge_valid` latency is 1 cycle; the address is registered together with the valid.
- Response-to-`rsp_core_sel_valid` latency is 1 cycle.
- Sustained throughput is 1 request/cycle while `can_issue` stays high.
- `stage_full` takes effect the same cycle it is sampled: no acceptance occurs in a cycle where it is high.
- When `outstanding_cnt==OUTSTANDING_DEPTH`, ready is low. A response in that cycle re-enables ready in the following cycle, not the same cycle.
- Cores must hold address and valid stable until ready.

## Configuration
- **`HBM_ARB_ERR_CHECK_EN` defined:**
  - Adds output `rsp_underflow_err` (1 bit, sticky, cleared only by `rst`).
  - The flag sets when `hbm_rsp_valid` arrives with the tag FIFO empty.
  - The failed pop produces no `rsp_core_sel_valid`, and `outstanding_cnt` stays 0.
- **Not defined:**
  - The port is absent.
  - A response with an empty FIFO is ignored: no pop, no select output, and the counter saturates at 0.

## Test plan
- **Round-robin:** all 4 valids held high, `stage_full`=0, responses returning → grants in order 0,1,2,3,0. `rd_hbm_edge_addr` carries each core's address one cycle after its ready.
- **Back-pressure:** `stage_full`=1 for 5 cycles with core 2 valid → `core_rd_ready`=0 and no `rd_hbm_edge_valid` throughout. After `stage_full` falls, core 2 is accepted in the first cycle, and valid appears one cycle later.
- **Outstanding limit:** issue 32 requests from core 1 with no responses → `outstanding_cnt`=32 and ready drops. One `hbm_rsp_valid` → next cycle `rsp_core_sel`=4'b0010, and ready returns the cycle after.
- **Response routing:** issue cores 3,0,0,2, then 4 back-to-back responses → `rsp_core_sel` = 1000, 0001, 0001, 0100 on consecutive cycles, and `outstanding_cnt` ends at 0 with `idle`=1.
- **Simultaneous accept and response:** with `outstanding_cnt`=5, accept and response in the same cycle → count stays 5 and the select matches the oldest tag.
- **Reset and underflow:** assert `rst` with 3 reads outstanding, then send `hbm_rsp_valid` → all outputs 0 and `outstanding_cnt`=0. With `HBM_ARB_ERR_CHECK_EN` defined, `rsp_underflow_err`=1 and stays set until `rst`.
